// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a hardwired zero register, optional write
// bypass, optional registered reads and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] select_a,
    input  logic [ADDR_W-1:0] select_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserve_address,
    output logic [ADDR_W:0]   busy_count
);
    localparam int NSEL = 1 << ADDR_W;

    // Storage spans the full address space; entries outside DEPTH are never written.
    logic [WIDTH-1:0] regs_r [NSEL];
    logic [NSEL-1:0]  busy_r;
    logic [ADDR_W:0]  busy_count_r;
    logic [NSEL-1:0]  busy_next_s;
    logic             wr_ok_s;
    logic             rsv_ok_s;
    logic [WIDTH-1:0] eff_a_s;
    logic [WIDTH-1:0] eff_b_s;

    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NSEL-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NSEL; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Qualify write/reserve and form the next busy vector (a reserve beats a write).
    always_comb begin
        wr_ok_s  = write && addr_live(address);
        rsv_ok_s = reserve && addr_live(reserve_address);
        busy_next_s = busy_r;
        for (int i = 0; i < NSEL; i++) begin
            busy_next_s[i] = (rsv_ok_s && (reserve_address == ADDR_W'(i))) ? 1'b1 :
                             (wr_ok_s && (address == ADDR_W'(i)))          ? 1'b0 :
                             busy_r[i];
        end
    end

    // Effective read value of port A.
    always_comb begin
        if (!addr_live(select_a)) begin
            eff_a_s = '0;
        end else if ((BYPASS != 0) && write && (address == select_a)) begin
            eff_a_s = data_in;
        end else begin
            eff_a_s = regs_r[select_a];
        end
    end

    // Effective read value of port B.
    always_comb begin
        if (!addr_live(select_b)) begin
            eff_b_s = '0;
        end else if ((BYPASS != 0) && write && (address == select_b)) begin
            eff_b_s = data_in;
        end else begin
            eff_b_s = regs_r[select_b];
        end
    end

    // Register array, scoreboard bits and busy population count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSEL; i++) begin
                regs_r[i] <= '0;
            end
            busy_r       <= '0;
            busy_count_r <= '0;
        end else begin
            if (wr_ok_s) begin
                regs_r[address] <= data_in;
            end
            busy_r       <= busy_next_s;
            busy_count_r <= popcount(busy_next_s);
        end
    end

    // A write in flight hides the busy flag unless a new reservation lands on it too.
    assign busy_a = busy_r[select_a] & ~((BYPASS != 0) & write & (address == select_a)
                    & ~(reserve & (reserve_address == select_a)));
    assign busy_b = busy_r[select_b] & ~((BYPASS != 0) & write & (address == select_b)
                    & ~(reserve & (reserve_address == select_b)));
    assign busy_count = busy_count_r;

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] out_a_r;
            logic [WIDTH-1:0] out_b_r;

            // Registered read ports: one cycle of latency from select to data.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_a_r <= '0;
                    out_b_r <= '0;
                end else begin
                    out_a_r <= eff_a_s;
                    out_b_r <= eff_b_s;
                end
            end
            assign out_a = out_a_r;
            assign out_b = out_b_r;
        end else begin : g_rd_comb
            assign out_a = eff_a_s;
            assign out_b = eff_b_s;
        end
    endgenerate
endmodule
